// File: rtl/main_memory_controller.sv
// Unified byte-addressed main memory serving instruction-cache word fetches and
// data-side byte/half/word accesses, with data priority and a shared status bus.
module main_memory_controller #(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned LEN          = 32,
  parameter int unsigned BYTE_SIZE    = 8,
  parameter int unsigned DATA_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] inst_vis_addr,
  input  logic [1:0]            inst_vis_signal,
  output logic [LEN-1:0]        inst_data,
  input  logic [ADDR_WIDTH-1:0] data_vis_addr,
  input  logic [1:0]            data_vis_signal,
  input  logic [1:0]            data_size,
  input  logic [LEN-1:0]        data_wdata,
  output logic [LEN-1:0]        data_rdata,
  output logic                  data_done,
  output logic [1:0]            mem_status
);

  localparam logic [1:0] MEM_READ         = 2'd1;
  localparam logic [1:0] MEM_WRITE        = 2'd2;
  localparam logic [1:0] MEM_RESTING      = 2'd0;
  localparam logic [1:0] MEM_INST_WORKING = 2'd1;
  localparam logic [1:0] MEM_DATA_WORKING = 2'd2;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] INST_RESP = 2'd1;
  localparam logic [1:0] DATA_BUSY = 2'd2;

  localparam int unsigned NB        = LEN / BYTE_SIZE;
  localparam int unsigned MEM_BYTES = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT  = 4'(DATA_LATENCY - 1);

  logic [BYTE_SIZE-1:0] mem [MEM_BYTES];

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic [LEN-1:0]        wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [1:0]            status_d;
  logic [LEN-1:0]        inst_data_d, rdata_d;
  logic                  done_d;
  logic                  mem_we;
  logic                  data_req;
  int unsigned           nbytes;
  logic [LEN-1:0]        inst_word, data_word;

  // Size code 3 behaves as a full word.
  function automatic int unsigned size_bytes(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return NB;
    endcase
  endfunction

  assign nbytes   = size_bytes(size_q);
  assign data_req = (data_vis_signal == MEM_READ) || (data_vis_signal == MEM_WRITE);

  // Little-endian assembly; address arithmetic wraps at the top of memory.
  always_comb begin
    inst_word = '0;
    data_word = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      inst_word[i*BYTE_SIZE +: BYTE_SIZE] = mem[inst_vis_addr + ADDR_WIDTH'(i)];
      if (i < nbytes) begin
        data_word[i*BYTE_SIZE +: BYTE_SIZE] = mem[addr_q + ADDR_WIDTH'(i)];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    status_d    = mem_status;
    inst_data_d = inst_data;
    rdata_d     = data_rdata;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req) begin
          state_d  = DATA_BUSY;
          addr_d   = data_vis_addr;
          size_d   = data_size;
          wdata_d  = data_wdata;
          write_d  = (data_vis_signal == MEM_WRITE);
          cnt_d    = CNT_INIT;
          status_d = MEM_DATA_WORKING;
        end else if (inst_vis_signal == MEM_READ) begin
          state_d     = INST_RESP;
          inst_data_d = inst_word;
          status_d    = MEM_INST_WORKING;
        end
      end
      INST_RESP: begin
        state_d  = IDLE;
        status_d = MEM_RESTING;
      end
      DATA_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we = write_q;
          if (!write_q) rdata_d = data_word;
          done_d   = 1'b1;
          state_d  = IDLE;
          status_d = MEM_RESTING;
        end
      end
      default: begin
        state_d  = IDLE;
        status_d = MEM_RESTING;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      mem_status <= MEM_RESTING;
      inst_data  <= '0;
      data_rdata <= '0;
      data_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      mem_status <= status_d;
      inst_data  <= inst_data_d;
      data_rdata <= rdata_d;
      data_done  <= done_d;
    end
  end

  // Array is deliberately unreset; reset drops state to IDLE so no write commits.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (i < nbytes) mem[addr_q + ADDR_WIDTH'(i)] <= wdata_q[i*BYTE_SIZE +: BYTE_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_main_memory_controller.sv
// Scoreboard bench for main_memory_controller: drivers push expected responses,
// a negedge monitor pops and compares on data_done and MEM_INST_WORKING cycles.
module tb_main_memory_controller;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] inst_vis_addr = '0;
  logic [1:0]    inst_vis_signal = 2'd0;
  logic [31:0]   inst_data;
  logic [AW-1:0] data_vis_addr = '0;
  logic [1:0]    data_vis_signal = 2'd0;
  logic [1:0]    data_size = 2'd0;
  logic [31:0]   data_wdata = '0;
  logic [31:0]   data_rdata;
  logic          data_done;
  logic [1:0]    mem_status;

  main_memory_controller #(
    .ADDR_WIDTH(AW), .LEN(32), .BYTE_SIZE(8), .DATA_LATENCY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_vis_addr(inst_vis_addr), .inst_vis_signal(inst_vis_signal), .inst_data(inst_data),
    .data_vis_addr(data_vis_addr), .data_vis_signal(data_vis_signal), .data_size(data_size),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .mem_status(mem_status)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  mref [0:(1<<AW)-1];
  logic [31:0] exp_rdata = '0;
  logic [31:0] dq[$];
  logic [31:0] iq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected response", name);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a, input logic [1:0] sz);
    logic [31:0] v = '0;
    for (int i = 0; i < nbytes(sz); i++) v[8*i +: 8] = mref[a + AW'(i)];
    return v;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) mref[a + AW'(i)] = wd[8*i +: 8];
  endtask

  // Monitor: compare whenever the DUT presents a response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_done) begin
        if (dq.size() == 0) fail_now("data_done_unexpected");
        else check("data_rdata", data_rdata, dq.pop_front());
      end
      if (mem_status == 2'd1) begin
        if (iq.size() == 0) fail_now("inst_unexpected");
        else check("inst_data", inst_data, iq.pop_front());
      end
      if (mem_status == 2'd3) check("status_never_3", {30'd0, mem_status}, 32'd0);
    end
  end

  task automatic data_op(input bit wr, input logic [AW-1:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, output logic [31:0] seen);
    bit acc = 1'b0;
    bit fin = 1'b0;
    seen = '0;
    @(posedge clk); #1;
    data_vis_addr   = a;
    data_size       = sz;
    data_wdata      = wd;
    data_vis_signal = wr ? 2'd2 : 2'd1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(posedge clk); #1;
      if (mem_status == 2'd2) acc = 1'b1;
    end
    data_vis_signal = 2'd0;
    if (!acc) begin
      fail_now("data_accept");
      return;
    end
    if (wr) model_write(a, sz, wd);
    else exp_rdata = model_read(a, sz);
    dq.push_back(exp_rdata);
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      if (data_done) begin
        seen = data_rdata;
        fin  = 1'b1;
      end
    end
    if (!fin) fail_now("data_done_wait");
  endtask

  task automatic inst_op(input logic [AW-1:0] a);
    bit acc = 1'b0;
    @(posedge clk); #1;
    inst_vis_addr   = a;
    inst_vis_signal = 2'd1;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(posedge clk); #1;
      if (mem_status == 2'd1) begin
        acc = 1'b1;
        iq.push_back(model_read(a, 2'd2));
      end
    end
    inst_vis_signal = 2'd0;
    if (!acc) fail_now("inst_accept");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    int bad;
    logic [1:0] stat [5];
    logic       dn [5];
    logic [1:0] exp_stat [5] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd0};
    logic       exp_dn   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < (1 << AW); i++) mref[i] = 8'h00;
    #23 rst_n = 1'b1;
    check("rst_status", {30'd0, mem_status}, 32'd0);
    check("rst_inst_data", inst_data, 32'd0);
    check("rst_rdata", data_rdata, 32'd0);
    check("rst_done", {31'd0, data_done}, 32'd0);

    // Instruction fetch latency and status sequence.
    data_op(1'b1, 17'h0, 2'd2, 32'h00100513, s);
    @(posedge clk); #1;
    iq.push_back(model_read(17'h0, 2'd2));
    inst_vis_addr = 17'h0; inst_vis_signal = 2'd1;
    @(posedge clk); #1;
    inst_vis_signal = 2'd0;
    check("fetch_status", {30'd0, mem_status}, 32'd1);
    check("fetch_word", inst_data, 32'h00100513);
    @(posedge clk); #1;
    check("fetch_rest", {30'd0, mem_status}, 32'd0);

    // Simultaneous requests: data wins, held inst served once after the resting cycle.
    data_op(1'b1, 17'h4, 2'd2, 32'h00A00093, s);
    @(posedge clk); #1;
    inst_vis_addr = 17'h4; inst_vis_signal = 2'd1;
    data_vis_addr = 17'h200; data_size = 2'd2; data_wdata = 32'hCAFEF00D; data_vis_signal = 2'd2;
    model_write(17'h200, 2'd2, 32'hCAFEF00D);
    dq.push_back(exp_rdata);
    iq.push_back(model_read(17'h4, 2'd2));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      stat[c] = mem_status;
      dn[c]   = data_done;
      if (c == 0) data_vis_signal = 2'd0;
      if (mem_status == 2'd1) inst_vis_signal = 2'd0;
    end
    inst_vis_signal = 2'd0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("arb_status_%0d", c), {30'd0, stat[c]}, {30'd0, exp_stat[c]});
      check($sformatf("arb_done_%0d", c), {31'd0, dn[c]}, {31'd0, exp_dn[c]});
    end
    check("arb_inst_word", inst_data, 32'h00A00093);

    // Byte merge and sub-word reads.
    data_op(1'b1, 17'h201, 2'd0, 32'h000000AB, s);
    data_op(1'b0, 17'h200, 2'd2, 32'h0, s);
    check("word_after_byte", s, 32'hCAFEAB0D);
    data_op(1'b0, 17'h202, 2'd1, 32'h0, s);
    check("half_read", s, 32'h0000CAFE);

    // Top-of-memory wrap.
    data_op(1'b1, 17'h1FFFE, 2'd2, 32'h11223344, s);
    data_op(1'b0, 17'h1FFFE, 2'd0, 32'h0, s); check("wrap_b0", s, 32'h44);
    data_op(1'b0, 17'h1FFFF, 2'd0, 32'h0, s); check("wrap_b1", s, 32'h33);
    data_op(1'b0, 17'h00000, 2'd0, 32'h0, s); check("wrap_b2", s, 32'h22);
    data_op(1'b0, 17'h00001, 2'd0, 32'h0, s); check("wrap_b3", s, 32'h11);
    data_op(1'b0, 17'h1FFFE, 2'd2, 32'h0, s); check("wrap_word", s, 32'h11223344);

    // Reset mid-write abandons it.
    data_op(1'b1, 17'h100, 2'd2, 32'h0, s);
    data_op(1'b0, 17'h200, 2'd2, 32'h0, s);
    @(posedge clk); #1;
    data_vis_addr = 17'h100; data_size = 2'd2; data_wdata = 32'hDEADBEEF; data_vis_signal = 2'd2;
    @(posedge clk); #1;
    data_vis_signal = 2'd0;
    check("rst_mid_busy", {30'd0, mem_status}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_status", {30'd0, mem_status}, 32'd0);
    check("rst_mid_done", {31'd0, data_done}, 32'd0);
    check("rst_mid_rdata", data_rdata, 32'd0);
    check("rst_mid_inst", inst_data, 32'd0);
    #2 rst_n = 1'b1;
    exp_rdata = '0;
    data_op(1'b0, 17'h100, 2'd2, 32'h0, s);
    check("rst_write_dropped", s, 32'h0);

    // Signal code 3 is a no-op.
    bad = 0;
    @(posedge clk); #1;
    data_vis_signal = 2'd3;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (mem_status != 2'd0 || data_done) bad++;
    end
    data_vis_signal = 2'd0;
    check("sig3_ignored", 32'(bad), 32'd0);

    // Initialise a wrapping window, then randomised concurrent traffic.
    for (int i = 0; i < 12; i++)
      data_op(1'b1, AW'(17'h1FFF0 + 4 * i), 2'd2, $urandom, s);
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          logic [AW-1:0] a;
          a = AW'(17'h1FFF0 + $urandom_range(0, 43));
          data_op(1'($urandom), a, 2'($urandom), $urandom, s);
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          logic [AW-1:0] a;
          a = AW'(17'h1FFF0 + $urandom_range(0, 44));
          inst_op(a);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join
    repeat (4) @(posedge clk);
    check("queues_drained", 32'(dq.size() + iq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
